spi_command_framer: RTL and testbench



---
 rtl/spi_command_framer.sv | 126 ++++++++++++
 tb/tb_spi_command_framer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_command_framer.sv
// Frames a chip-select delimited SPI byte stream into opcode/operand strobes
// for the graphics command block. All outputs are registered.
module spi_command_framer #(
    parameter int unsigned MAX_OPERANDS = 65535,
    parameter int unsigned COUNT_WIDTH  = 32
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   cs_active_in,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid_in,
    output logic [7:0]             op_code_out,
    output logic                   op_code_valid_out,
    output logic [7:0]             operand_out,
    output logic                   operand_valid_out,
    output logic [COUNT_WIDTH-1:0] operand_count_out,
    output logic                   overflow_out,
    output logic                   frame_done_out
);
    typedef enum logic [1:0] {IDLE, WAIT_OPCODE, OPERANDS, OVERFLOW} state_t;

    localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(MAX_OPERANDS);

    state_t                 r_state, w_state_nxt;
    logic                   r_armed;
    logic [7:0]             r_op_code, w_op_code_nxt;
    logic                   r_op_valid, w_op_valid_nxt;
    logic [7:0]             r_operand, w_operand_nxt;
    logic                   r_operand_valid, w_operand_valid_nxt;
    logic [COUNT_WIDTH-1:0] r_count, w_count_nxt;
    logic                   r_overflow, w_overflow_nxt;
    logic                   r_done, w_done_nxt;
    logic                   w_take_opcode;

    // An opcode can land straight from IDLE so a one-cycle cs gap costs no extra cycle.
    assign w_take_opcode = cs_active_in && byte_valid_in &&
                           ((r_state == IDLE && r_armed) || r_state == WAIT_OPCODE);

    always_comb begin
        w_state_nxt         = r_state;
        w_op_code_nxt       = r_op_code;
        w_op_valid_nxt      = r_op_valid;
        w_operand_nxt       = r_operand;
        w_operand_valid_nxt = 1'b0;
        w_count_nxt         = r_count;
        w_overflow_nxt      = r_overflow;
        w_done_nxt          = 1'b0;

        if (w_take_opcode) begin
            w_op_code_nxt  = byte_in;
            w_op_valid_nxt = 1'b1;
            w_count_nxt    = '0;
            w_state_nxt    = OPERANDS;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cs_active_in && r_armed)
                        w_state_nxt = WAIT_OPCODE;
                end
                WAIT_OPCODE: begin
                    if (!cs_active_in)
                        w_state_nxt = IDLE;
                end
                OPERANDS, OVERFLOW: begin
                    if (!cs_active_in) begin
                        w_state_nxt    = IDLE;
                        w_op_valid_nxt = 1'b0;
                        w_count_nxt    = '0;
                        w_overflow_nxt = 1'b0;
                        w_done_nxt     = 1'b1;
                    end else if (byte_valid_in && r_state == OPERANDS) begin
                        if (r_count >= MAX_CNT) begin
                            w_state_nxt    = OVERFLOW;
                            w_overflow_nxt = 1'b1;
                        end else begin
                            w_operand_nxt       = byte_in;
                            w_count_nxt         = r_count + COUNT_WIDTH'(1);
                            w_operand_valid_nxt = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // r_armed blocks a frame already in progress when reset is released.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= IDLE;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (!cs_active_in)
                r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_op_code       <= '0;
            r_op_valid      <= 1'b0;
            r_operand       <= '0;
            r_operand_valid <= 1'b0;
            r_count         <= '0;
            r_overflow      <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_op_code       <= w_op_code_nxt;
            r_op_valid      <= w_op_valid_nxt;
            r_operand       <= w_operand_nxt;
            r_operand_valid <= w_operand_valid_nxt;
            r_count         <= w_count_nxt;
            r_overflow      <= w_overflow_nxt;
            r_done          <= w_done_nxt;
        end
    end

    assign op_code_out       = r_op_code;
    assign op_code_valid_out = r_op_valid;
    assign operand_out       = r_operand;
    assign operand_valid_out = r_operand_valid;
    assign operand_count_out = r_count;
    assign overflow_out      = r_overflow;
    assign frame_done_out    = r_done;
endmodule

// File: tb/tb_spi_command_framer.sv
// Bench for spi_command_framer: a default-depth instance and a MAX_OPERANDS=2
// instance share stimulus and are compared every cycle against a frame-level model.
module tb_spi_command_framer;
    logic        clock_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        cs_active_in = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid_in = 1'b0;

    logic [7:0]  op0, opr0, op1, opr1;
    logic        opv0, orv0, ovf0, dn0, opv1, orv1, ovf1, dn1;
    logic [31:0] cnt0, cnt1;

    int errors = 0;
    int checks = 0;

    always #5 clock_in = ~clock_in;

    spi_command_framer dut0 (
        .clock_in(clock_in), .reset_in(reset_in), .cs_active_in(cs_active_in),
        .byte_in(byte_in), .byte_valid_in(byte_valid_in),
        .op_code_out(op0), .op_code_valid_out(opv0), .operand_out(opr0),
        .operand_valid_out(orv0), .operand_count_out(cnt0),
        .overflow_out(ovf0), .frame_done_out(dn0));

    spi_command_framer #(.MAX_OPERANDS(2)) dut1 (
        .clock_in(clock_in), .reset_in(reset_in), .cs_active_in(cs_active_in),
        .byte_in(byte_in), .byte_valid_in(byte_valid_in),
        .op_code_out(op1), .op_code_valid_out(opv1), .operand_out(opr1),
        .operand_valid_out(orv1), .operand_count_out(cnt1),
        .overflow_out(ovf1), .frame_done_out(dn1));

    // {opcode, opcode_valid, operand, operand_valid, count, overflow, done}
    logic [51:0] act [2];
    assign act[0] = {op0, opv0, opr0, orv0, cnt0, ovf0, dn0};
    assign act[1] = {op1, opv1, opr1, orv1, cnt1, ovf1, dn1};

    // Model: a frame is just "how many bytes have been accepted so far".
    int          maxv [2];
    int          m_n [2];
    logic        m_active [2];
    logic        m_armed = 1'b0;
    logic [7:0]  m_op [2];
    logic [7:0]  m_operand [2];
    logic        m_pulse [2];
    logic        m_done [2];
    logic [51:0] expv [2];

    task automatic tick(input logic cs, input logic bv, input logic [7:0] b);
        int c;
        cs_active_in = cs; byte_valid_in = bv; byte_in = b;
        @(posedge clock_in);
        for (int d = 0; d < 2; d++) begin
            m_pulse[d] = 1'b0;
            m_done[d]  = 1'b0;
            if (reset_in) begin
                m_active[d] = 1'b0; m_n[d] = 0; m_op[d] = 8'h00; m_operand[d] = 8'h00;
            end else if (!cs) begin
                m_done[d]   = m_active[d] && (m_n[d] > 0);
                m_active[d] = 1'b0;
                m_n[d]      = 0;
            end else if (m_armed) begin
                m_active[d] = 1'b1;
                if (bv) begin
                    if (m_n[d] == 0) m_op[d] = b;
                    else if (m_n[d] <= maxv[d]) begin m_operand[d] = b; m_pulse[d] = 1'b1; end
                    m_n[d]++;
                end
            end
            c = (m_active[d] && m_n[d] > 0) ? ((m_n[d] - 1 > maxv[d]) ? maxv[d] : m_n[d] - 1) : 0;
            expv[d] = {m_op[d], m_active[d] && (m_n[d] > 0), m_operand[d], m_pulse[d],
                       32'(c), m_active[d] && (m_n[d] - 1 > maxv[d]), m_done[d]};
        end
        m_armed = reset_in ? 1'b0 : (m_armed || !cs);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] stim [$];
        #3;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (act[d] !== 52'h0) begin
                errors++; $display("FAIL reset_state dut%0d got=%h want=0", d, act[d]);
            end
        end
        tick(1'b0, 1'b0, 8'h00);
        reset_in = 1'b0;
        stim = '{10'h000, 10'h000};
        foreach (stim[i]) begin
            tick(stim[i][9], stim[i][8], stim[i][7:0]);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (act[d] !== expv[d]) begin
                    errors++; $display("FAIL reset_idle dut%0d got=%h want=%h", d, act[d], expv[d]);
                end
            end
        end
    endtask

    task automatic test_basic_frame();
        logic [9:0] stim [$] = '{10'h312, 10'h301, 10'h340, 10'h300, 10'h3C8, 10'h000, 10'h000};
        foreach (stim[i]) begin
            tick(stim[i][9], stim[i][8], stim[i][7:0]);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (act[d] !== expv[d]) begin
                    errors++; $display("FAIL basic_frame dut%0d step%0d got=%h want=%h", d, i, act[d], expv[d]);
                end
            end
            if (i == 4) begin
                checks++;
                if ({cnt0, opr0, orv0} !== {32'd4, 8'hC8, 1'b1}) begin
                    errors++; $display("FAIL basic_fourth_operand got=%0d/%h/%b want=4/c8/1", cnt0, opr0, orv0);
                end
            end
            if (i == 5) begin
                checks++;
                if ({dn0, opv0, cnt0, op0} !== {1'b1, 1'b0, 32'd0, 8'h12}) begin
                    errors++; $display("FAIL basic_frame_end got=%b/%b/%0d/%h want=1/0/0/12", dn0, opv0, cnt0, op0);
                end
            end
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] stim [$] = '{10'h310, 10'h200, 10'h200, 10'h000, 10'h000};
        int pulses = 0, dones = 0;
        foreach (stim[i]) begin
            tick(stim[i][9], stim[i][8], stim[i][7:0]);
            pulses += int'(orv0); dones += int'(dn0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (act[d] !== expv[d]) begin
                    errors++; $display("FAIL single_byte dut%0d step%0d got=%h want=%h", d, i, act[d], expv[d]);
                end
            end
        end
        checks++;
        if (pulses !== 0 || dones !== 1) begin
            errors++; $display("FAIL single_byte_counts pulses=%0d dones=%0d want 0/1", pulses, dones);
        end
    endtask

    task automatic test_overflow();
        logic [9:0] stim [$] = '{10'h316, 10'h3AA, 10'h3BB, 10'h3CC, 10'h200, 10'h3DD, 10'h000, 10'h000};
        foreach (stim[i]) begin
            tick(stim[i][9], stim[i][8], stim[i][7:0]);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (act[d] !== expv[d]) begin
                    errors++; $display("FAIL overflow dut%0d step%0d got=%h want=%h", d, i, act[d], expv[d]);
                end
            end
            if (i == 3 || i == 5) begin
                checks++;
                if ({ovf1, cnt1, orv1, opr1} !== {1'b1, 32'd2, 1'b0, 8'hBB}) begin
                    errors++; $display("FAIL overflow_hold got=%b/%0d/%b/%h want=1/2/0/bb", ovf1, cnt1, orv1, opr1);
                end
            end
            if (i == 6) begin
                checks++;
                if ({ovf1, dn1, cnt1} !== {1'b0, 1'b1, 32'd0}) begin
                    errors++; $display("FAIL overflow_clear got=%b/%b/%0d want=0/1/0", ovf1, dn1, cnt1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] stim [$] = '{10'h319, 10'h355, 10'h000, 10'h310, 10'h366, 10'h000, 10'h000};
        foreach (stim[i]) begin
            tick(stim[i][9], stim[i][8], stim[i][7:0]);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (act[d] !== expv[d]) begin
                    errors++; $display("FAIL back_to_back dut%0d step%0d got=%h want=%h", d, i, act[d], expv[d]);
                end
            end
            if (i == 2) begin
                checks++;
                if ({opv0, op0, dn0} !== {1'b0, 8'h19, 1'b1}) begin
                    errors++; $display("FAIL b2b_gap got=%b/%h/%b want=0/19/1", opv0, op0, dn0);
                end
            end
            if (i == 3) begin
                checks++;
                if ({opv0, op0} !== {1'b1, 8'h10}) begin
                    errors++; $display("FAIL b2b_second got=%b/%h want=1/10", opv0, op0);
                end
            end
        end
    endtask

    task automatic test_ignored_bytes();
        logic [9:0] stim [$] = '{10'h321, 10'h322, 10'h1EE, 10'h1EF, 10'h000,
                                 10'h200, 10'h200, 10'h200, 10'h000, 10'h000};
        foreach (stim[i]) begin
            tick(stim[i][9], stim[i][8], stim[i][7:0]);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (act[d] !== expv[d]) begin
                    errors++; $display("FAIL ignored dut%0d step%0d got=%h want=%h", d, i, act[d], expv[d]);
                end
            end
            if (i == 2 || i == 3) begin
                checks++;
                if ({orv0, opr0, cnt0} !== {1'b0, 8'h22, 32'd0}) begin
                    errors++; $display("FAIL ignored_cs_low got=%b/%h/%0d want=0/22/0", orv0, opr0, cnt0);
                end
            end
            if (i == 8) begin
                checks++;
                if ({dn0, opv0} !== 2'b00) begin
                    errors++; $display("FAIL empty_frame got done=%b valid=%b want 0/0", dn0, opv0);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] stim [$] = '{10'h331, 10'h301, 10'h302};
        logic [9:0] post [$] = '{10'h3A0, 10'h3A1, 10'h200, 10'h000, 10'h342, 10'h343, 10'h000};
        foreach (stim[i]) tick(stim[i][9], stim[i][8], stim[i][7:0]);
        checks++;
        if ({opv0, cnt0} !== {1'b1, 32'd2}) begin
            errors++; $display("FAIL pre_reset got=%b/%0d want=1/2", opv0, cnt0);
        end
        #2 reset_in = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (act[d] !== 52'h0) begin
                errors++; $display("FAIL async_reset dut%0d got=%h want=0", d, act[d]);
            end
        end
        tick(1'b1, 1'b1, 8'h99);
        reset_in = 1'b0;
        foreach (post[i]) begin
            tick(post[i][9], post[i][8], post[i][7:0]);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (act[d] !== expv[d]) begin
                    errors++; $display("FAIL reset_mid dut%0d step%0d got=%h want=%h", d, i, act[d], expv[d]);
                end
            end
            if (i == 2) begin
                checks++;
                if ({opv0, op0, dn0} !== {1'b0, 8'h00, 1'b0}) begin
                    errors++; $display("FAIL stale_frame got=%b/%h/%b want=0/00/0", opv0, op0, dn0);
                end
            end
            if (i == 4) begin
                checks++;
                if ({opv0, op0} !== {1'b1, 8'h42}) begin
                    errors++; $display("FAIL rearm got=%b/%h want=1/42", opv0, op0);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] stim [$];
        for (int f = 0; f < 40; f++) begin
            int len = $urandom_range(0, 6);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) stim.push_back({2'b10, 8'($urandom)});
                stim.push_back({2'b11, 8'($urandom)});
            end
            repeat ($urandom_range(0, 1)) stim.push_back({2'b10, 8'($urandom)});
            repeat ($urandom_range(1, 3)) stim.push_back({1'b0, 1'($urandom), 8'($urandom)});
        end
        foreach (stim[i]) begin
            tick(stim[i][9], stim[i][8], stim[i][7:0]);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (act[d] !== expv[d]) begin
                    errors++; $display("FAIL random dut%0d step%0d got=%h want=%h", d, i, act[d], expv[d]);
                end
            end
        end
    endtask

    initial begin
        maxv[0] = 65535; maxv[1] = 2;
        for (int d = 0; d < 2; d++) begin
            m_n[d] = 0; m_active[d] = 1'b0; m_op[d] = 8'h00; m_operand[d] = 8'h00;
            m_pulse[d] = 1'b0; m_done[d] = 1'b0; expv[d] = '0;
        end
        test_reset();
        test_basic_frame();
        test_single_byte();
        test_overflow();
        test_back_to_back();
        test_ignored_bytes();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
